vend_dispense_arbiter: RTL and testbench
========================================

# vend_dispense_arbiter

Shared-dispenser controller for a multi-kiosk vending front end. Each kiosk port has its own coin input and credit accumulator. When a port's credit reaches the product price, it requests the single dispense mechanism. A round-robin arbiter grants one port at a time, runs a start/done handshake with the mechanism, then issues per-port product and change pulses and clears that port's credit.

## Interface
- `NPORT`, default 2: number of kiosk ports. Legal range 2..4.
- `PRICE`, default 3: product price in coin units. Legal range 1..4.
- `TIMEOUT`, default 15: maximum cycles spent in WAIT before abort. Used only with `VEND_TIMEOUT_EN`.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `coin  in  2*NPORT`: coin code per port, port p at bits [2p+1:2p]. 0 = none, 1 = one unit, 2 = two units, 3 = invalid.
- `disp_done  in  1`: mechanism finished the current vend.
- `disp_start  out  1`: one-cycle request to the mechanism.
- `disp_port  out  2`: granted port index. Valid while `disp_start` is high.
- `product  out  NPORT`: one-cycle vend pulse, one bit per port.
- `change  out  NPORT`: one-cycle change pulse, one bit per port. Asserted together with `product` when credit exceeds `PRICE`.
- `coin_rej  out  NPORT`: one-cycle pulse for a refused coin.
- `fault  out  1`: sticky dispenser-timeout flag.

## Operation
- Per-port credit register, 3 bits, reset 0. A valid coin is sampled at a rising edge and added at that same edge.
- Port p is pending when credit[p] ≥ `PRICE`.
- A coin that arrives while port p is pending or granted is refused:
  - credit is unchanged;
  - `coin_rej[p]` is high for the next cycle.
- Coin code 3 is always refused the same way.
- Max credit is `PRICE`−1+2, so `change` is at most one unit.
- FSM states: IDLE, GRANT, WAIT, DONE.
  - IDLE: if any port is pending, select one round-robin and go to GRANT. Otherwise stay in IDLE.
  - GRANT: drive `disp_start`=1 and `disp_port`=g. Go to WAIT unconditionally.
  - WAIT: when `disp_done`=1, go to DONE. `disp_done` is ignored in every other state.
  - DONE: drive `product[g]`=1, and `change[g]`=1 if credit[g] > `PRICE`. Clear credit[g] at the exiting edge. Update the round-robin pointer to g. Go to IDLE.
- Round-robin search starts at pointer+1 and wraps modulo `NPORT`. The pointer resets to `NPORT`−1, so port 0 wins the first tie.
- Non-granted ports keep accepting coins and may become pending in any state.
- Reset values:
  - state IDLE, all credits 0, pointer `NPORT`−1;
  - `disp_start`, `product`, `change`, `coin_rej` all 0;
  - `disp_port` 0, `fault` 0.
- Reset mid-vend: the FSM returns to IDLE, all credit is lost, and no `product` or `change` pulse is issued.

## Timing
- All outputs are decoded from registered state or registered pulse flops. Nothing combinational runs from `coin` or `disp_done` to any output.
- A coin at edge k that makes port p pending: if the FSM is in IDLE, GRANT is entered at edge k+1. `disp_start` is high during cycle k+1→k+2.
- `disp_done` sampled high at edge m in WAIT: DONE is entered at m, and the pulses are high during cycle m→m+1. IDLE is re-entered at m+1.
- Minimum grant-to-grant spacing: 4 cycles. This occurs with `disp_done` high on the first WAIT cycle.
- Coin on a non-granted port in the same cycle as DONE: accepted normally.
- Coin on the granted port during DONE: refused. Credit clears regardless.

## Configuration
- `VEND_TIMEOUT_EN` defined:
  - a 4-bit counter clears on entering WAIT and increments each WAIT cycle without `disp_done`;
  - at count = `TIMEOUT` the FSM goes to IDLE, `fault` is set and stays set until `rst`;
  - credit[g] is retained, no `product` pulse is issued, and the pointer still advances to g.
- `VEND_TIMEOUT_EN` undefined: WAIT holds indefinitely, `fault` is tied to 0, and no counter is built.

## Test plan
- Port 0: coin=1 then coin=2. → `disp_start`=1 with `disp_port`=0 one cycle after the second coin. Apply `disp_done` in the first WAIT cycle. → `product[0]`=1, `change[0]`=0, credit 0.
- Port 1: coin=2, 2 (credit 4). → same handshake, ending with `product[1]`=1 and `change[1]`=1.
- Both ports reach credit 3 at the same edge, from reset. → port 0 is granted first and port 1 second. Repeat the tie. → port 0 wins again, because the pointer was left at 1.
- Port 0 pending, then port 0 coin=1 and port 1 coin=3. → `coin_rej`=2'b11 for one cycle, and both credits are unchanged.
- `rst` pulsed during WAIT. → next cycle IDLE, all outputs 0, credits 0, no `product` pulse.
- `VEND_TIMEOUT_EN` defined, `TIMEOUT`=15, `disp_done` never asserted. → after 15 WAIT cycles: `fault`=1, FSM back in IDLE, port still pending, so re-granted 1 cycle later.

Source files
------------

// File: rtl/vend_if.sv
// Kiosk-side and dispenser-side signals of the vend arbiter, bundled for port connection.
interface vend_if #(
    parameter int NPORT = 2
);
    logic [2*NPORT-1:0] coin;
    logic               disp_done;
    logic               disp_start;
    logic [1:0]         disp_port;
    logic [NPORT-1:0]   product;
    logic [NPORT-1:0]   change;
    logic [NPORT-1:0]   coin_rej;
    logic               fault;

    modport master (
        input  coin, disp_done,
        output disp_start, disp_port, product, change, coin_rej, fault
    );

    modport slave (
        output coin, disp_done,
        input  disp_start, disp_port, product, change, coin_rej, fault
    );
endinterface

// File: rtl/vend_dispense_arbiter.sv
// Round-robin arbiter sharing one dispense mechanism between NPORT coin-fed kiosk ports.
// Define VEND_TIMEOUT_EN to abort a stalled WAIT after TIMEOUT cycles and raise a sticky fault.
//
//   state | meaning
//   IDLE  | no vend in progress, searching for a pending port
//   GRANT | disp_start pulse to the mechanism for port grant_q
//   WAIT  | waiting for disp_done from the mechanism
//   DONE  | product/change pulses for grant_q, its credit clears on exit
module vend_dispense_arbiter #(
    parameter int NPORT   = 2,
    parameter int PRICE   = 3,
    parameter int TIMEOUT = 15
) (
    input logic    clk,
    input logic    rst,
    vend_if.master bus
);
    typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} state_t;

    localparam logic [2:0] PRICE_C = 3'(PRICE);

    if (NPORT < 2 || NPORT > 4 || PRICE < 1 || PRICE > 4 || TIMEOUT < 1 || TIMEOUT > 15) begin : g_param_check
        $error("vend_dispense_arbiter: parameter out of range");
    end

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [2:0]       credit_q [NPORT];
    logic [2:0]       credit_d [NPORT];
    logic [NPORT-1:0] pending;
    logic [NPORT-1:0] rej_d, rej_q;
    logic [NPORT-1:0] prod_sel, chg_sel;

`ifdef VEND_TIMEOUT_EN
    logic [3:0] cnt_q, cnt_d;
    logic       fault_q, fault_d;
`endif

    always_comb begin
        pending = '0;
        for (int p = 0; p < NPORT; p++) pending[p] = (credit_q[p] >= PRICE_C);
    end

    always_comb begin
        logic found;
        found   = 1'b0;
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
`ifdef VEND_TIMEOUT_EN
        cnt_d   = cnt_q;
        fault_d = fault_q;
`endif
        case (state_q)
            IDLE: begin
                // offset k=1 is the port just after the last winner
                for (int k = 1; k <= NPORT; k++) begin
                    for (int i = 0; i < NPORT; i++) begin
                        if (!found && pending[i] && ((int'(ptr_q) + k) % NPORT == i)) begin
                            found   = 1'b1;
                            grant_d = 2'(i);
                        end
                    end
                end
                if (found) state_d = GRANT;
            end
            GRANT: begin
                state_d = WAIT;
`ifdef VEND_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (bus.disp_done) state_d = DONE;
`ifdef VEND_TIMEOUT_EN
                else if (cnt_q == 4'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    fault_d = 1'b1;
                    ptr_d   = grant_q;
                end else cnt_d = cnt_q + 4'd1;
`endif
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = grant_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // A port that is pending or owns the mechanism refuses further coins.
    always_comb begin
        rej_d = '0;
        for (int p = 0; p < NPORT; p++) begin
            credit_d[p] = credit_q[p];
            if (bus.coin[2*p +: 2] == 2'd3 ||
                (bus.coin[2*p +: 2] != 2'd0 &&
                 (pending[p] || (state_q != IDLE && grant_q == 2'(p)))))
                rej_d[p] = 1'b1;
            else if (bus.coin[2*p +: 2] != 2'd0)
                credit_d[p] = credit_q[p] + {1'b0, bus.coin[2*p +: 2]};
            if (state_q == DONE && grant_q == 2'(p)) credit_d[p] = '0;
        end
    end

    always_comb begin
        prod_sel = '0;
        chg_sel  = '0;
        for (int p = 0; p < NPORT; p++) begin
            prod_sel[p] = (state_q == DONE) && (grant_q == 2'(p));
            chg_sel[p]  = prod_sel[p] && (credit_q[p] > PRICE_C);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= 2'(NPORT - 1);
            rej_q   <= '0;
            for (int p = 0; p < NPORT; p++) credit_q[p] <= '0;
`ifdef VEND_TIMEOUT_EN
            cnt_q   <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            rej_q   <= rej_d;
            for (int p = 0; p < NPORT; p++) credit_q[p] <= credit_d[p];
`ifdef VEND_TIMEOUT_EN
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
`endif
        end
    end

    assign bus.disp_start = (state_q == GRANT);
    assign bus.disp_port  = grant_q;
    assign bus.product    = prod_sel;
    assign bus.change     = chg_sel;
    assign bus.coin_rej   = rej_q;
`ifdef VEND_TIMEOUT_EN
    assign bus.fault      = fault_q;
`else
    assign bus.fault      = 1'b0;
`endif
endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Scoreboard bench for vend_dispense_arbiter: expected vends queued at coin time, checked at dispense.
module tb_vend_dispense_arbiter;
    localparam int NPORT = 2, PRICE = 3, TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    vend_if #(.NPORT(NPORT)) bus ();
    vend_dispense_arbiter #(.NPORT(NPORT), .PRICE(PRICE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .bus(bus));

    typedef struct { int port; logic chg; } exp_t;
    exp_t exp_q[$];
    int n_cmp = 0, n_err = 0;

    task automatic tick(); @(posedge clk); #1; endtask

    task automatic drive_coin(input logic [1:0] c0, input logic [1:0] c1);
        bus.coin = {c1, c0}; tick(); bus.coin = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.coin = '0; bus.disp_done = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Waits for disp_start, runs the handshake, reports what the DUT did.
    task automatic serve(input int delay, input logic [3:0] done_coin, output bit ok,
                         output int port, output int t_start, output logic [1:0] prod,
                         output logic [1:0] chg, output logic [1:0] rej, output logic [1:0] prod_after);
        ok = 0; port = -1; t_start = 0; prod = '0; chg = '0; rej = '0; prod_after = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.disp_start === 1'b1) ok = 1; else tick();
        end
        if (!ok) return;
        port = int'(bus.disp_port); t_start = cyc;
        tick();
        repeat (delay) tick();
        bus.disp_done = 1'b1; tick(); bus.disp_done = 1'b0;
        prod = bus.product; chg = bus.change;
        bus.coin = done_coin; tick(); bus.coin = '0;
        rej = bus.coin_rej; prod_after = bus.product;
    endtask

    bit ok; int port, t0, t1; logic [1:0] prod, chg, rej, pa;
    exp_t e;

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.disp_start !== 1'b0) begin n_err++; $display("FAIL reset_start got %b want 0", bus.disp_start); end
        n_cmp++; if (bus.disp_port !== 2'd0) begin n_err++; $display("FAIL reset_port got %0d want 0", bus.disp_port); end
        n_cmp++; if ({bus.product, bus.change} !== 4'b0) begin n_err++; $display("FAIL reset_pulses got %b want 0000", {bus.product, bus.change}); end
        n_cmp++; if (bus.coin_rej !== 2'b00) begin n_err++; $display("FAIL reset_rej got %b want 00", bus.coin_rej); end
        n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got %b want 0", bus.fault); end
    endtask

    task automatic test_port0();
        bit seen;
        drive_coin(2'd1, 2'd0);
        drive_coin(2'd2, 2'd0);
        exp_q.push_back('{0, 1'b0});
        n_cmp++; if (bus.disp_start !== 1'b0) begin n_err++; $display("FAIL p0_early_start got %b want 0", bus.disp_start); end
        tick();
        n_cmp++; if ({bus.disp_start, bus.disp_port} !== 3'b100) begin n_err++; $display("FAIL p0_start got %b want 100", {bus.disp_start, bus.disp_port}); end
        serve(0, 4'd0, ok, port, t0, prod, chg, rej, pa);
        e = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1 || port !== e.port) begin n_err++; $display("FAIL p0_grant got ok=%0d port=%0d want port %0d", ok, port, e.port); end
        n_cmp++; if ({prod, chg, pa} !== {2'b01, 2'b00, 2'b00}) begin n_err++; $display("FAIL p0_pulses got %b want 010000", {prod, chg, pa}); end
        // credit must be 0 again: coin 2 must not make it pending
        drive_coin(2'd2, 2'd0);
        seen = 0;
        repeat (4) begin tick(); if (bus.disp_start === 1'b1) seen = 1; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL p0_cleared got start=%0d want 0", seen); end
        drive_coin(2'd1, 2'd0);
        exp_q.push_back('{0, 1'b0});
        serve(0, 4'd0, ok, port, t0, prod, chg, rej, pa);
        e = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1 || port !== e.port || chg !== 2'b00) begin n_err++; $display("FAIL p0_refill got port=%0d chg=%b want port %0d chg 00", port, chg, e.port); end
    endtask

    task automatic test_port1_change();
        drive_coin(2'd0, 2'd2);
        drive_coin(2'd0, 2'd2);
        exp_q.push_back('{1, 1'b1});
        serve(0, 4'd0, ok, port, t0, prod, chg, rej, pa);
        e = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1 || port !== e.port) begin n_err++; $display("FAIL p1_grant got ok=%0d port=%0d want port %0d", ok, port, e.port); end
        n_cmp++; if ({prod, chg} !== {2'b10, (e.chg ? 2'b10 : 2'b00)}) begin n_err++; $display("FAIL p1_change got %b want 1010", {prod, chg}); end
    endtask

    task automatic test_tie();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            drive_coin(2'd1, 2'd2);
            drive_coin(2'd2, 2'd1);
            exp_q.push_back('{0, 1'b0});
            exp_q.push_back('{1, 1'b0});
            serve(0, 4'd0, ok, port, t0, prod, chg, rej, pa);
            e = exp_q.pop_front();
            n_cmp++; if (ok !== 1'b1 || port !== e.port || prod !== 2'b01) begin n_err++; $display("FAIL tie%0d_first got port=%0d prod=%b want port %0d", r, port, prod, e.port); end
            serve(0, 4'd0, ok, port, t1, prod, chg, rej, pa);
            e = exp_q.pop_front();
            n_cmp++; if (ok !== 1'b1 || port !== e.port || prod !== 2'b10) begin n_err++; $display("FAIL tie%0d_second got port=%0d prod=%b want port %0d", r, port, prod, e.port); end
            n_cmp++; if (t1 - t0 !== 4) begin n_err++; $display("FAIL tie%0d_spacing got %0d want 4", r, t1 - t0); end
        end
    endtask

    task automatic test_reject();
        drive_coin(2'd1, 2'd0);
        drive_coin(2'd2, 2'd0);
        exp_q.push_back('{0, 1'b0});
        drive_coin(2'd1, 2'd3);
        n_cmp++; if (bus.coin_rej !== 2'b11) begin n_err++; $display("FAIL rej_pulse got %b want 11", bus.coin_rej); end
        serve(0, 4'd0, ok, port, t0, prod, chg, rej, pa);
        e = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1 || port !== e.port || {prod, chg} !== 4'b0100) begin n_err++; $display("FAIL rej_p0 got port=%0d pc=%b want port 0 pc 0100", port, {prod, chg}); end
        drive_coin(2'd0, 2'd2);
        drive_coin(2'd0, 2'd1);
        exp_q.push_back('{1, 1'b0});
        serve(0, 4'd0, ok, port, t0, prod, chg, rej, pa);
        e = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1 || port !== e.port || {prod, chg} !== 4'b1000) begin n_err++; $display("FAIL rej_p1 got port=%0d pc=%b want port 1 pc 1000", port, {prod, chg}); end
    endtask

    task automatic test_done_coin();
        drive_coin(2'd2, 2'd0);
        drive_coin(2'd1, 2'd0);
        exp_q.push_back('{0, 1'b0});
        serve(1, {2'd2, 2'd1}, ok, port, t0, prod, chg, rej, pa);
        e = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1 || port !== e.port || prod !== 2'b01) begin n_err++; $display("FAIL done_vend got port=%0d prod=%b want port 0 prod 01", port, prod); end
        n_cmp++; if (rej !== 2'b01 || pa !== 2'b00) begin n_err++; $display("FAIL done_rej got rej=%b prod_after=%b want 01 00", rej, pa); end
        drive_coin(2'd0, 2'd1);
        exp_q.push_back('{1, 1'b0});
        serve(0, 4'd0, ok, port, t0, prod, chg, rej, pa);
        e = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1 || port !== e.port || {prod, chg} !== 4'b1000) begin n_err++; $display("FAIL done_p1 got port=%0d pc=%b want port 1 pc 1000", port, {prod, chg}); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        drive_coin(2'd1, 2'd0);
        drive_coin(2'd2, 2'd0);
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++; if ({bus.disp_start, bus.disp_port, bus.product, bus.change, bus.coin_rej} !== 9'b0) begin n_err++; $display("FAIL mid_outputs got %b want 0", {bus.disp_start, bus.disp_port, bus.product, bus.change, bus.coin_rej}); end
        bus.disp_done = 1'b1;
        seen = 0;
        repeat (3) begin tick(); if (bus.product !== 2'b00 || bus.disp_start !== 1'b0) seen = 1; end
        bus.disp_done = 1'b0;
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_no_vend got activity=%0d want 0", seen); end
        drive_coin(2'd2, 2'd0);
        seen = 0;
        repeat (3) begin tick(); if (bus.disp_start === 1'b1) seen = 1; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_credit_lost got start=%0d want 0", seen); end
        drive_coin(2'd1, 2'd0);
        exp_q.push_back('{0, 1'b0});
        serve(0, 4'd0, ok, port, t0, prod, chg, rej, pa);
        e = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1 || port !== e.port || {prod, chg} !== 4'b0100) begin n_err++; $display("FAIL mid_revend got port=%0d pc=%b want port 0 pc 0100", port, {prod, chg}); end
    endtask

    task automatic test_timeout();
        int n;
        bit prod_seen;
        drive_coin(2'd1, 2'd0);
        drive_coin(2'd2, 2'd0);
        tick();
        n_cmp++; if (bus.disp_start !== 1'b1) begin n_err++; $display("FAIL to_start got %b want 1", bus.disp_start); end
        tick();
        n = 0; prod_seen = 0;
`ifdef VEND_TIMEOUT_EN
        for (int i = 0; i < 40 && bus.fault !== 1'b1; i++) begin
            tick(); n++;
            if (bus.product !== 2'b00) prod_seen = 1;
        end
        n_cmp++; if (n !== TIMEOUT || prod_seen !== 1'b0) begin n_err++; $display("FAIL to_fault got wait=%0d prod=%0d want %0d 0", n, prod_seen, TIMEOUT); end
        tick();
        n_cmp++; if ({bus.disp_start, bus.disp_port} !== 3'b100) begin n_err++; $display("FAIL to_regrant got %b want 100", {bus.disp_start, bus.disp_port}); end
        exp_q.push_back('{0, 1'b0});
        serve(0, 4'd0, ok, port, t0, prod, chg, rej, pa);
        e = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1 || port !== e.port || {prod, chg} !== 4'b0100 || bus.fault !== 1'b1) begin n_err++; $display("FAIL to_vend got port=%0d pc=%b fault=%b want 0 0100 1", port, {prod, chg}, bus.fault); end
`else
        for (int i = 0; i < 40; i++) begin
            tick(); n++;
            if (bus.product !== 2'b00 || bus.fault !== 1'b0) prod_seen = 1;
        end
        n_cmp++; if (prod_seen !== 1'b0) begin n_err++; $display("FAIL to_hold got activity=%0d want 0", prod_seen); end
        bus.disp_done = 1'b1; tick(); bus.disp_done = 1'b0;
        n_cmp++; if ({bus.product, bus.change} !== 4'b0100) begin n_err++; $display("FAIL to_late_done got %b want 0100", {bus.product, bus.change}); end
        tick();
`endif
    endtask

    initial begin
        bus.coin = '0; bus.disp_done = 1'b0;
        test_reset();
        test_port0();
        test_port1_change();
        test_tie();
        test_reject();
        test_done_coin();
        test_reset_mid();
        test_timeout();
        n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
